// File: rtl/nvdla_dbb_host_bridge.sv
// nvdla_dbb_host_bridge
// AXI bridge from the NVDLA DBB master port (narrow data, wide ID) to the
// SNAP host-memory AXI master (wide data, narrow ID). Narrow-size INCR
// bursts are issued on the host side. Byte lanes are placed on writes and
// extracted on reads. DBB IDs are restored from in-order tracking FIFOs.
// The NVDLA level interrupt is also converted to the SNAP interrupt/ack
// handshake.
// Optional build macro: NVDLA_BRIDGE_PERF_CNT_EN adds saturating
// performance counters (perf_rd_beats, perf_wr_beats, perf_rd_stall).

// Small synchronous FIFO used for the in-order ID / lane tracking.
module nvdla_dbb_host_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; push and pop are independent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write.
  // NOTE: storage is deliberately not reset; the pointers alone define
  // validity, and leaving the array unreset lets it map onto RAM/LUTRAM.
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
endmodule

module nvdla_dbb_host_bridge #(
  parameter int DBB_DATA_WIDTH  = 64,
  parameter int DBB_ID_WIDTH    = 8,
  parameter int DBB_LEN_WIDTH   = 4,
  parameter int ADDR_WIDTH      = 64,
  parameter int HOST_DATA_WIDTH = 512,
  parameter int HOST_ID_WIDTH   = 1,
  parameter int MAX_OUTSTANDING = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_OFFSET = '0
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  // DBB write address
  input  logic                         dbb_awvalid,
  output logic                         dbb_awready,
  input  logic [DBB_ID_WIDTH-1:0]      dbb_awid,
  input  logic [DBB_LEN_WIDTH-1:0]     dbb_awlen,
  input  logic [ADDR_WIDTH-1:0]        dbb_awaddr,
  // DBB write data
  input  logic                         dbb_wvalid,
  output logic                         dbb_wready,
  input  logic [DBB_DATA_WIDTH-1:0]    dbb_wdata,
  input  logic [DBB_DATA_WIDTH/8-1:0]  dbb_wstrb,
  input  logic                         dbb_wlast,
  // DBB write response
  output logic                         dbb_bvalid,
  input  logic                         dbb_bready,
  output logic [DBB_ID_WIDTH-1:0]      dbb_bid,
  // DBB read address
  input  logic                         dbb_arvalid,
  output logic                         dbb_arready,
  input  logic [DBB_ID_WIDTH-1:0]      dbb_arid,
  input  logic [DBB_LEN_WIDTH-1:0]     dbb_arlen,
  input  logic [ADDR_WIDTH-1:0]        dbb_araddr,
  // DBB read data
  output logic                         dbb_rvalid,
  input  logic                         dbb_rready,
  output logic [DBB_ID_WIDTH-1:0]      dbb_rid,
  output logic                         dbb_rlast,
  output logic [DBB_DATA_WIDTH-1:0]    dbb_rdata,
  // Host AW
  output logic                         m_axi_host_mem_awvalid,
  input  logic                         m_axi_host_mem_awready,
  output logic [ADDR_WIDTH-1:0]        m_axi_host_mem_awaddr,
  output logic [7:0]                   m_axi_host_mem_awlen,
  output logic [2:0]                   m_axi_host_mem_awsize,
  output logic [1:0]                   m_axi_host_mem_awburst,
  output logic [3:0]                   m_axi_host_mem_awcache,
  output logic [HOST_ID_WIDTH-1:0]     m_axi_host_mem_awid,
  output logic                         m_axi_host_mem_awlock,
  output logic [2:0]                   m_axi_host_mem_awprot,
  output logic [3:0]                   m_axi_host_mem_awqos,
  output logic [3:0]                   m_axi_host_mem_awregion,
  output logic                         m_axi_host_mem_awuser,
  // Host W
  output logic                         m_axi_host_mem_wvalid,
  input  logic                         m_axi_host_mem_wready,
  output logic [HOST_DATA_WIDTH-1:0]   m_axi_host_mem_wdata,
  output logic [HOST_DATA_WIDTH/8-1:0] m_axi_host_mem_wstrb,
  output logic                         m_axi_host_mem_wlast,
  output logic                         m_axi_host_mem_wuser,
  // Host B
  input  logic                         m_axi_host_mem_bvalid,
  output logic                         m_axi_host_mem_bready,
  input  logic [1:0]                   m_axi_host_mem_bresp,
  input  logic [HOST_ID_WIDTH-1:0]     m_axi_host_mem_bid,
  // Host AR
  output logic                         m_axi_host_mem_arvalid,
  input  logic                         m_axi_host_mem_arready,
  output logic [ADDR_WIDTH-1:0]        m_axi_host_mem_araddr,
  output logic [7:0]                   m_axi_host_mem_arlen,
  output logic [2:0]                   m_axi_host_mem_arsize,
  output logic [1:0]                   m_axi_host_mem_arburst,
  output logic [3:0]                   m_axi_host_mem_arcache,
  output logic [HOST_ID_WIDTH-1:0]     m_axi_host_mem_arid,
  output logic                         m_axi_host_mem_arlock,
  output logic [2:0]                   m_axi_host_mem_arprot,
  output logic [3:0]                   m_axi_host_mem_arqos,
  output logic [3:0]                   m_axi_host_mem_arregion,
  output logic                         m_axi_host_mem_aruser,
  // Host R
  input  logic                         m_axi_host_mem_rvalid,
  output logic                         m_axi_host_mem_rready,
  input  logic [HOST_DATA_WIDTH-1:0]   m_axi_host_mem_rdata,
  input  logic [1:0]                   m_axi_host_mem_rresp,
  input  logic                         m_axi_host_mem_rlast,
  input  logic [HOST_ID_WIDTH-1:0]     m_axi_host_mem_rid,
  // Interrupt and status
  input  logic                         nvdla_intr,
  output logic                         interrupt,
  input  logic                         interrupt_ack,
  output logic                         err_sticky
`ifdef NVDLA_BRIDGE_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_rd_beats,
  output logic [31:0]                  perf_wr_beats,
  output logic [31:0]                  perf_rd_stall
`endif
);
  localparam int RATIO = HOST_DATA_WIDTH / DBB_DATA_WIDTH;
  localparam int SB    = DBB_DATA_WIDTH / 8;
  localparam int LB    = $clog2(SB);
  localparam int HB    = $clog2(HOST_DATA_WIDTH / 8);
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // ---------------------------------------------------------------- lanes
  logic [LW-1:0] ar_lane, aw_lane;

  if (RATIO > 1) begin : g_lane
    assign ar_lane = dbb_araddr[HB-1:LB];
    assign aw_lane = dbb_awaddr[HB-1:LB];
  end else begin : g_nolane
    assign ar_lane = '0;
    assign aw_lane = '0;
  end

  // ----------------------------------------------------------- read path
  logic                         rf_full, rf_empty;
  logic [DBB_ID_WIDTH+LW-1:0]   rf_dout;
  logic [DBB_ID_WIDTH-1:0]      rf_id;
  logic [LW-1:0]                rf_lane;
  logic [LW-1:0]                r_beat_q, r_beat_d, r_lane;
  logic                         ar_hs, r_hs, r_pop;

  assign m_axi_host_mem_arvalid  = dbb_arvalid & ~rf_full;
  assign dbb_arready             = m_axi_host_mem_arready & ~rf_full;
  assign ar_hs                   = m_axi_host_mem_arvalid & m_axi_host_mem_arready;
  assign m_axi_host_mem_araddr   = dbb_araddr + ADDR_OFFSET;
  assign m_axi_host_mem_arlen    = 8'(dbb_arlen);
  assign m_axi_host_mem_arsize   = 3'(LB);
  assign m_axi_host_mem_arburst  = 2'b01;
  assign m_axi_host_mem_arcache  = 4'b0011;
  assign m_axi_host_mem_arid     = '0;
  assign m_axi_host_mem_arlock   = 1'b0;
  assign m_axi_host_mem_arprot   = 3'b000;
  assign m_axi_host_mem_arqos    = 4'b0000;
  assign m_axi_host_mem_arregion = 4'b0000;
  assign m_axi_host_mem_aruser   = 1'b0;

  nvdla_dbb_host_bridge_fifo #(
    .WIDTH (DBB_ID_WIDTH + LW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rfifo (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .push_i  (ar_hs),
    .din_i   ({dbb_arid, ar_lane}),
    .pop_i   (r_pop),
    .dout_o  (rf_dout),
    .full_o  (rf_full),
    .empty_o (rf_empty)
  );

  assign {rf_id, rf_lane}       = rf_dout;
  assign dbb_rvalid             = m_axi_host_mem_rvalid & ~rf_empty;
  assign m_axi_host_mem_rready  = dbb_rready & ~rf_empty;
  assign r_hs                   = dbb_rvalid & dbb_rready;
  assign r_pop                  = r_hs & m_axi_host_mem_rlast;
  assign r_lane                 = (RATIO > 1) ? LW'(rf_lane + r_beat_q) : '0;
  assign dbb_rdata              = m_axi_host_mem_rdata[r_lane*DBB_DATA_WIDTH +: DBB_DATA_WIDTH];
  assign dbb_rid                = rf_id;
  assign dbb_rlast              = m_axi_host_mem_rlast;

  // Read beat counter: advances per beat, clears on the last beat.
  always_comb begin
    r_beat_d = r_beat_q;
    if (r_hs) r_beat_d = m_axi_host_mem_rlast ? '0 : LW'(r_beat_q + 1'b1);
  end

  // ---------------------------------------------------------- write path
  logic          wf_full, wf_empty, bf_full, bf_empty;
  logic [LW-1:0] wf_lane, w_beat_q, w_beat_d, w_lane;
  logic          aw_hs, w_hs, w_pop, b_hs;

  assign m_axi_host_mem_awvalid  = dbb_awvalid & ~wf_full & ~bf_full;
  assign dbb_awready             = m_axi_host_mem_awready & ~wf_full & ~bf_full;
  assign aw_hs                   = m_axi_host_mem_awvalid & m_axi_host_mem_awready;
  assign m_axi_host_mem_awaddr   = dbb_awaddr + ADDR_OFFSET;
  assign m_axi_host_mem_awlen    = 8'(dbb_awlen);
  assign m_axi_host_mem_awsize   = 3'(LB);
  assign m_axi_host_mem_awburst  = 2'b01;
  assign m_axi_host_mem_awcache  = 4'b0011;
  assign m_axi_host_mem_awid     = '0;
  assign m_axi_host_mem_awlock   = 1'b0;
  assign m_axi_host_mem_awprot   = 3'b000;
  assign m_axi_host_mem_awqos    = 4'b0000;
  assign m_axi_host_mem_awregion = 4'b0000;
  assign m_axi_host_mem_awuser   = 1'b0;

  nvdla_dbb_host_bridge_fifo #(
    .WIDTH (LW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_wfifo (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .push_i  (aw_hs),
    .din_i   (aw_lane),
    .pop_i   (w_pop),
    .dout_o  (wf_lane),
    .full_o  (wf_full),
    .empty_o (wf_empty)
  );

  nvdla_dbb_host_bridge_fifo #(
    .WIDTH (DBB_ID_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_bfifo (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .push_i  (aw_hs),
    .din_i   (dbb_awid),
    .pop_i   (b_hs),
    .dout_o  (dbb_bid),
    .full_o  (bf_full),
    .empty_o (bf_empty)
  );

  // W data is held off until the AW that owns it has been accepted.
  assign m_axi_host_mem_wvalid = dbb_wvalid & ~wf_empty;
  assign dbb_wready            = m_axi_host_mem_wready & ~wf_empty;
  assign w_hs                  = m_axi_host_mem_wvalid & m_axi_host_mem_wready;
  assign w_pop                 = w_hs & dbb_wlast;
  assign w_lane                = (RATIO > 1) ? LW'(wf_lane + w_beat_q) : '0;
  assign m_axi_host_mem_wdata  = {RATIO{dbb_wdata}};
  assign m_axi_host_mem_wlast  = dbb_wlast;
  assign m_axi_host_mem_wuser  = 1'b0;

  // Strobes only in the active lane; the replicated data is harmless elsewhere.
  // NOTE: the default assignment first keeps this block latch-free.
  always_comb begin
    m_axi_host_mem_wstrb = '0;
    m_axi_host_mem_wstrb[w_lane*SB +: SB] = dbb_wstrb;
  end

  // Write beat counter: advances per beat, clears on the last beat.
  always_comb begin
    w_beat_d = w_beat_q;
    if (w_hs) w_beat_d = dbb_wlast ? '0 : LW'(w_beat_q + 1'b1);
  end

  assign dbb_bvalid            = m_axi_host_mem_bvalid & ~bf_empty;
  assign m_axi_host_mem_bready = dbb_bready & ~bf_empty;
  assign b_hs                  = dbb_bvalid & dbb_bready;

  // ----------------------------------------------------------- error flag
  logic err_q, err_d;

  // Error flag sets on any non-OKAY response actually handshaked.
  always_comb begin
    err_d = err_q;
    if (b_hs && m_axi_host_mem_bresp != 2'b00) err_d = 1'b1;
    if (r_hs && m_axi_host_mem_rresp != 2'b00) err_d = 1'b1;
  end

  assign err_sticky = err_q;

  // ------------------------------------------------------ interrupt FSM
  logic [1:0] st_q, st_d;
  logic       intr_q, intr_qq, pend_q, pend_d, intr_rise;

  assign intr_rise = intr_q & ~intr_qq;
  assign interrupt = (st_q == ST_REQ);

  // Interrupt handshake next state; an edge seen while busy is remembered.
  always_comb begin
    st_d   = st_q;
    pend_d = pend_q | (intr_rise & (st_q != ST_IDLE));
    case (st_q)
      ST_IDLE: if (intr_rise) st_d = ST_REQ;
      ST_REQ:  if (interrupt_ack) st_d = ST_WAIT;
      ST_WAIT: begin
        if (!intr_q) begin
          st_d   = pend_d ? ST_REQ : ST_IDLE;
          pend_d = 1'b0;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  // All bridge state registers.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_beat_q <= '0;
      w_beat_q <= '0;
      err_q    <= 1'b0;
      st_q     <= ST_IDLE;
      pend_q   <= 1'b0;
      intr_q   <= 1'b0;
      intr_qq  <= 1'b0;
    end else begin
      r_beat_q <= r_beat_d;
      w_beat_q <= w_beat_d;
      err_q    <= err_d;
      st_q     <= st_d;
      pend_q   <= pend_d;
      intr_q   <= nvdla_intr;
      intr_qq  <= intr_q;
    end
  end

  // Host IDs are single-threaded on this port; they carry no information.
  logic unused_host_id;
  assign unused_host_id = ^{m_axi_host_mem_bid, m_axi_host_mem_rid};

`ifdef NVDLA_BRIDGE_PERF_CNT_EN
  logic [31:0] perf_rd_beats_q, perf_wr_beats_q, perf_rd_stall_q;

  // Saturating performance counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      perf_rd_beats_q <= '0;
      perf_wr_beats_q <= '0;
      perf_rd_stall_q <= '0;
    end else begin
      if (r_hs && perf_rd_beats_q != 32'hFFFF_FFFF)
        perf_rd_beats_q <= perf_rd_beats_q + 32'd1;
      if (w_hs && perf_wr_beats_q != 32'hFFFF_FFFF)
        perf_wr_beats_q <= perf_wr_beats_q + 32'd1;
      if (dbb_arvalid && !dbb_arready && perf_rd_stall_q != 32'hFFFF_FFFF)
        perf_rd_stall_q <= perf_rd_stall_q + 32'd1;
    end
  end

  assign perf_rd_beats = perf_rd_beats_q;
  assign perf_wr_beats = perf_wr_beats_q;
  assign perf_rd_stall = perf_rd_stall_q;
`endif
endmodule

// File: doc/nvdla_dbb_host_bridge.md
Name: nvdla_dbb_host_bridge

Overview:
- Parametrised AXI bridge between the NVDLA DBB master port (narrow data, wide ID) and the SNAP host-memory AXI master (512-bit, 1-bit ID); instantiated inside action_wrapper between the NVDLA core and m_axi_host_mem_*.
- Issues narrow-size INCR bursts, places and extracts byte lanes, and restores DBB IDs via in-order tracking FIFOs.
- Also converts the NVDLA level interrupt into the SNAP interrupt/ack handshake.

Parameters:
- DBB_DATA_WIDTH, 64, DBB data width; HOST_DATA_WIDTH/DBB_DATA_WIDTH must be a power of 2 (1..8).
- DBB_ID_WIDTH, 8, DBB transaction ID width.
- DBB_LEN_WIDTH, 4, DBB burst-length width.
- ADDR_WIDTH, 64, address width on both sides.
- HOST_DATA_WIDTH, 512, host data width.
- HOST_ID_WIDTH, 1, host ID width.
- MAX_OUTSTANDING, 8, depth of each tracking FIFO (power of 2).
- ADDR_OFFSET, 64'h0, added to every DBB address.

Ports:
- ap_clk  in  1  single clock.
- ap_rst_n  in  1  async active-low reset.
- dbb_aw{valid,ready,id,len,addr}  in/out/in/in/in  1/1/DBB_ID_WIDTH/DBB_LEN_WIDTH/ADDR_WIDTH  DBB write address.
- dbb_w{valid,ready,data,strb,last}  in/out/in/in/in  1/1/DBB_DATA_WIDTH/DBB_DATA_WIDTH/8/1  DBB write data.
- dbb_b{valid,ready,id}  out/in/out  1/1/DBB_ID_WIDTH  DBB write response.
- dbb_ar{valid,ready,id,len,addr}  as AW  DBB read address.
- dbb_r{valid,ready,id,last,data}  out/in/out/out/out  1/1/DBB_ID_WIDTH/1/DBB_DATA_WIDTH  DBB read data.
- m_axi_host_mem_*  per SNAP host AXI  full AW/W/B/AR/R master channels.
- nvdla_intr  in  1  NVDLA level interrupt.
- interrupt  out  1  to SNAP; interrupt_ack  in  1  from SNAP.
- err_sticky  out  1  any non-OKAY bresp/rresp seen.

Behaviour:
- Reset: all FIFOs empty, lane counters 0; every valid output, interrupt, err_sticky = 0. Reset mid-burst drops all in-flight state; no recovery of partial bursts.
- RATIO = HOST_DATA_WIDTH/DBB_DATA_WIDTH; LB = log2(DBB_DATA_WIDTH/8); lane field = addr[log2(HOST_DATA_WIDTH/8)-1:LB].
- AR: m_arvalid = dbb_arvalid & !rfifo_full; dbb_arready = m_arready & !rfifo_full; combinational, zero latency. araddr = dbb_araddr + ADDR_OFFSET (mod 2^ADDR_WIDTH); arlen = zero-extended dbb_arlen; arsize = LB; arburst = INCR; arcache = 4'b0011; arid, arlock, arprot, arqos, arregion, aruser = 0. Handshake pushes {id, start lane} into rfifo.
- R: dbb_rvalid = m_rvalid & !rfifo_empty; m_rready = dbb_rready & !rfifo_empty. dbb_rdata = rdata lane (start lane + beat count) mod RATIO; dbb_rid = head id; dbb_rlast = m_rlast. Beat counter increments on each handshake, clears and pops rfifo on the rlast handshake.
- AW: gated identically on !wfifo_full & !bfifo_full; pushes start lane into wfifo and id into bfifo on the same handshake; field mapping as AR.
- W: W stalls until its AW is accepted: m_wvalid = dbb_wvalid & !wfifo_empty; dbb_wready likewise gated. wdata = dbb_wdata replicated RATIO times; wstrb = dbb_wstrb in the current lane, 0 elsewhere; wlast passed. Lane advances per beat and wraps; wfifo pops on the wlast handshake.
- B: dbb_bvalid = m_bvalid & !bfifo_empty; dbb_bid = head; pops on handshake.
- Simultaneous push and pop on a full FIFO: the pop is accepted; the push is blocked because ready is already low that cycle.
- err_sticky is set on any handshaked resp != 2'b00 and cleared only by reset.
- Interrupt FSM:
  - IDLE -> REQ on a rising edge of nvdla_intr (registered); interrupt = 1 in REQ.
  - REQ -> WAIT on interrupt_ack; WAIT -> IDLE when nvdla_intr = 0.
  - An edge arriving during REQ/WAIT is not lost: level still high -> the WAIT exit is deferred.
- m_axi_host_mem_wuser = 0.

Optional Feature:
- NVDLA_BRIDGE_PERF_CNT_EN defined:
  - Adds outputs perf_rd_beats[31:0], perf_wr_beats[31:0] and perf_rd_stall[31:0].
  - perf_rd_stall counts cycles with dbb_arvalid & !dbb_arready.
  - All three counters saturate at 32'hFFFFFFFF and reset to 0.
- Not defined: these ports and their logic are absent.

Test Plan:
- Read, defaults: AR id=8'h5A, addr=0x1008, len=3; host returns 4 beats with lane 1..4 patterns -> m_araddr=0x1008, arsize=3, arlen=3; DBB beats carry lanes 1,2,3,4 with rid=0x5A; rlast on beat 4.
- Lane wrap: AR addr=0x1038, len=1 -> beat0 from lane 7, beat1 from lane 0.
- Write: AW id=3, addr=0x2010; 2 beats strb=8'hFF -> wstrb = 0xFF<<16, then 0xFF<<24; single bid=3.
- Backpressure: MAX_OUTSTANDING=8, 9 ARs with no R -> 9th held (dbb_arready=0) until the first rlast completes.
- Error/interrupt: bresp=2'b10 -> err_sticky=1 held; nvdla_intr pulse -> interrupt=1 until ack, then 0; second edge -> reasserts.
- Reset mid-burst: assert ap_rst_n=0 after 2 of 4 R beats -> all valids 0, FIFOs empty; a new AR after release is serviced normally.
